// File: rtl/unload_nibble.sv
// Streams a captured (x, y) result pair out four bits per beat, LS nibble first, with ready/valid handshake.
// Optional macro UNLOAD_CHECK_EN appends one XOR check beat per operand to each frame.
module unload_nibble #(
  parameter int SIZE  = 32,
  parameter int BEATS = SIZE / 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_done,
  input  logic [SIZE-1:0] i_x,
  input  logic [SIZE-1:0] i_y,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [3:0]      o_x_nib,
  output logic [3:0]      o_y_nib,
  output logic            o_last,
  output logic            o_busy
);

  // state    | meaning
  // IDLE     | waiting for a rising edge of i_done
  // SEND     | presenting beats, advancing on i_ready
  // WAIT_LOW | frame done, waiting for i_done to drop
  typedef enum logic [1:0] {IDLE, SEND, WAIT_LOW} state_t;

`ifdef UNLOAD_CHECK_EN
  localparam int LAST_IDX = BEATS;
  localparam int CW       = $clog2(BEATS + 2);
`else
  localparam int LAST_IDX = BEATS - 1;
  localparam int CW       = $clog2(BEATS + 1);
`endif

  state_t          state;
  logic            done_q;
  logic [SIZE-1:0] shift_x;
  logic [SIZE-1:0] shift_y;
  logic [CW-1:0]   beat_cnt;
  logic            rise;
  logic            is_last;
  logic [3:0]      nib_x;
  logic [3:0]      nib_y;

  assign rise    = i_done & ~done_q;
  assign is_last = (beat_cnt == CW'(LAST_IDX));

`ifdef UNLOAD_CHECK_EN
  logic [3:0] chk_x;
  logic [3:0] chk_y;
  logic       is_chk;

  assign is_chk = (beat_cnt == CW'(BEATS));
  assign nib_x  = is_chk ? chk_x : shift_x[3:0];
  assign nib_y  = is_chk ? chk_y : shift_y[3:0];
`else
  assign nib_x  = shift_x[3:0];
  assign nib_y  = shift_y[3:0];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      shift_x  <= '0;
      shift_y  <= '0;
      beat_cnt <= '0;
`ifdef UNLOAD_CHECK_EN
      chk_x    <= 4'h0;
      chk_y    <= 4'h0;
`endif
    end else begin
      done_q <= i_done;
      case (state)
        IDLE: begin
          if (rise) begin
            shift_x  <= i_x;
            shift_y  <= i_y;
            beat_cnt <= '0;
`ifdef UNLOAD_CHECK_EN
            chk_x    <= 4'h0;
            chk_y    <= 4'h0;
`endif
            state    <= SEND;
          end
        end
        SEND: begin
          if (i_ready) begin
            shift_x  <= shift_x >> 4;
            shift_y  <= shift_y >> 4;
            beat_cnt <= beat_cnt + CW'(1);
`ifdef UNLOAD_CHECK_EN
            // fold only data beats into the running parity
            if (beat_cnt < CW'(BEATS)) begin
              chk_x <= chk_x ^ shift_x[3:0];
              chk_y <= chk_y ^ shift_y[3:0];
            end
`endif
            if (is_last) state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!i_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_valid = (state == SEND);
  assign o_busy  = o_valid;
  assign o_last  = o_valid & is_last;
  assign o_x_nib = o_valid ? nib_x : 4'h0;
  assign o_y_nib = o_valid ? nib_y : 4'h0;

endmodule

// File: tb/tb_unload_nibble.sv
// Self-checking bench for unload_nibble: directed frames plus randomized handshake against a queue model.
module tb_unload_nibble;
  localparam int SIZE  = 32;
  localparam int BEATS = SIZE / 4;
`ifdef UNLOAD_CHECK_EN
  localparam int NB = BEATS + 1;
`else
  localparam int NB = BEATS;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst, i_done, i_ready;
  logic [31:0] i_x, i_y;
  logic        o_valid, o_last, o_busy;
  logic [3:0]  o_x_nib, o_y_nib;

  int n_tests = 0;
  int n_fail  = 0;

  unload_nibble #(.SIZE(SIZE), .BEATS(BEATS)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_done(i_done), .i_x(i_x), .i_y(i_y),
    .i_ready(i_ready), .o_valid(o_valid), .o_x_nib(o_x_nib), .o_y_nib(o_y_nib),
    .o_last(o_last), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Beat k of a frame carrying operand v; beat BEATS is the XOR of all data nibbles.
  function automatic logic [3:0] exp_nib(input logic [31:0] v, input int k);
    logic [3:0] acc;
    acc = 4'h0;
    if (k < BEATS) return 4'((v >> (4 * k)) & 32'hF);
    for (int i = 0; i < BEATS; i++) acc = acc ^ 4'((v >> (4 * i)) & 32'hF);
    return acc;
  endfunction

  task automatic test_reset();
    logic [10:0] got;
    i_rst = 1'b1; i_done = 1'b0; i_ready = 1'b0; i_x = '0; i_y = '0;
    step(); step();
    got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
    n_tests++;
    if (got !== 11'h0) begin n_fail++; $display("FAIL reset_held got=%h exp=%h", got, 11'h0); end
    i_rst = 1'b0;
    step();
    got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
    n_tests++;
    if (got !== 11'h0) begin n_fail++; $display("FAIL reset_release got=%h exp=%h", got, 11'h0); end
  endtask

  task automatic test_basic();
    logic [10:0] got, exp;
    i_x = 32'h12345678; i_y = 32'h9ABCDEF0; i_ready = 1'b1; i_done = 1'b1;
    step();
    i_done = 1'b0;
    for (int k = 0; k < NB; k++) begin
      got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
      exp = {1'b1, 1'b1, (k == NB - 1), exp_nib(32'h12345678, k), exp_nib(32'h9ABCDEF0, k)};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL basic[%0d] got=%h exp=%h", k, got, exp); end
      step();
    end
    got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
    n_tests++;
    if (got !== 11'h0) begin n_fail++; $display("FAIL basic_end got=%h exp=%h", got, 11'h0); end
    step();
  endtask

  task automatic test_backpressure();
    logic [10:0] got, exp;
    int b, held, c;
    b = 0; held = 0; c = 1;
    i_x = 32'h12345678; i_y = 32'h9ABCDEF0; i_done = 1'b1; i_ready = 1'b1;
    step();
    i_done = 1'b0;
    while (b < NB && c < 40) begin
      i_ready = !((b == 2 || b == 5) && held < 2);
      got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
      exp = {1'b1, 1'b1, (b == NB - 1), exp_nib(32'h12345678, b), exp_nib(32'h9ABCDEF0, b)};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL bp[%0d] cyc %0d got=%h exp=%h", b, c, got, exp); end
      step();
      c++;
      if (i_ready) begin b++; held = 0; end
      else held++;
    end
    n_tests++;
    if (c - 1 !== NB + 4) begin n_fail++; $display("FAIL bp_end_cycle got=%0d exp=%0d", c - 1, NB + 4); end
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after got=%b exp=0", o_valid); end
    i_ready = 1'b1;
    step();
  endtask

  task automatic test_held_done();
    int beats;
    logic [10:0] got, exp;
    beats = 0;
    i_x = 32'hA5C3_1E7B; i_y = 32'h0F1E_2D3C; i_ready = 1'b1; i_done = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_valid) beats++;
    end
    n_tests++;
    if (beats !== NB) begin n_fail++; $display("FAIL held_beats got=%0d exp=%0d", beats, NB); end
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL held_idle got=%b exp=0", o_valid); end
    i_done = 1'b0;
    step();
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL held_low got=%b exp=0", o_valid); end
    i_done = 1'b1;
    step();
    i_done = 1'b0;
    got = {o_valid, o_x_nib, o_y_nib, 2'b00};
    exp = {1'b1, exp_nib(32'hA5C3_1E7B, 0), exp_nib(32'h0F1E_2D3C, 0), 2'b00};
    n_tests++;
    if (got !== exp) begin n_fail++; $display("FAIL held_restart got=%h exp=%h", got, exp); end
    for (int i = 0; i < NB + 2; i++) step();
  endtask

  task automatic test_reset_midframe();
    logic [10:0] got, exp;
    i_x = 32'h12345678; i_y = 32'h9ABCDEF0; i_ready = 1'b1; i_done = 1'b1;
    step(); step(); step(); step();
    n_tests++;
    if (o_x_nib !== exp_nib(32'h12345678, 3)) begin
      n_fail++; $display("FAIL rst_pre got=%h exp=%h", o_x_nib, exp_nib(32'h12345678, 3));
    end
    i_rst = 1'b1;
    step();
    got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
    n_tests++;
    if (got !== 11'h0) begin n_fail++; $display("FAIL rst_mid got=%h exp=%h", got, 11'h0); end
    i_rst = 1'b0;
    step();
    for (int k = 0; k < NB; k++) begin
      got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
      exp = {1'b1, 1'b1, (k == NB - 1), exp_nib(32'h12345678, k), exp_nib(32'h9ABCDEF0, k)};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL rst_refr[%0d] got=%h exp=%h", k, got, exp); end
      step();
    end
    i_done = 1'b0;
    step(); step();
  endtask

  task automatic test_retrigger();
    logic [10:0] got, exp;
    i_x = 32'h12345678; i_y = 32'h9ABCDEF0; i_ready = 1'b1; i_done = 1'b1;
    step();
    i_done = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (k == 2) begin i_done = 1'b1; i_x = 32'hFFFFFFFF; i_y = $urandom; end
      got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
      exp = {1'b1, 1'b1, (k == NB - 1), exp_nib(32'h12345678, k), exp_nib(32'h9ABCDEF0, k)};
      n_tests++;
      if (got !== exp) begin n_fail++; $display("FAIL retrig[%0d] got=%h exp=%h", k, got, exp); end
      step();
    end
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL retrig_end got=%b exp=0", o_valid); end
    i_done = 1'b0;
    step(); step();
  endtask

  task automatic test_random();
    logic [3:0]  qx[$], qy[$];
    logic [31:0] x, y;
    logic [10:0] got, exp;
    int guard;
    for (int f = 0; f < 10; f++) begin
      x = $urandom; y = $urandom;
      i_x = x; i_y = y; i_done = 1'b1;
      step();
      i_done = 1'b0;
      qx.delete(); qy.delete();
      for (int k = 0; k < NB; k++) begin qx.push_back(exp_nib(x, k)); qy.push_back(exp_nib(y, k)); end
      guard = 0;
      while (qx.size() > 0 && guard < 200) begin
        i_ready = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) begin i_done = ~i_done; i_x = $urandom; i_y = $urandom; end
        got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
        exp = {1'b1, 1'b1, (qx.size() == 1), qx[0], qy[0]};
        n_tests++;
        if (got !== exp) begin n_fail++; $display("FAIL rand[%0d] left %0d got=%h exp=%h", f, qx.size(), got, exp); end
        step();
        guard++;
        if (i_ready) begin void'(qx.pop_front()); void'(qy.pop_front()); end
      end
      n_tests++;
      if (guard >= 200) begin n_fail++; $display("FAIL rand_timeout[%0d] got=%0d exp<200", f, guard); end
      i_ready = 1'b1; i_done = 1'b0;
      got = {o_valid, o_busy, o_last, o_x_nib, o_y_nib};
      n_tests++;
      if (got !== 11'h0) begin n_fail++; $display("FAIL rand_end[%0d] got=%h exp=%h", f, got, 11'h0); end
      repeat ($urandom_range(2, 4)) step();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_held_done();
    test_reset_midframe();
    test_retrigger();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/unload_nibble.md
UNLOAD_NIBBLE -- requirements
Module: unload_nibble

Interface
REQ-001 The module SHALL have parameter SIZE, default 32, giving the result operand width in bits; SIZE SHALL be a multiple of 4.
REQ-002 The module SHALL have parameter BEATS, default SIZE/4, giving the nibbles per operand.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with ports named i_clk and i_rst.
REQ-004 Port list, in order:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_done  input  1  result-ready level from the point-multiply control.
- i_x  input  SIZE  final x result (kPx).
- i_y  input  SIZE  final y result (kPy).
- i_ready  input  1  downstream accepts the current beat.
- o_valid  output  1  a beat is presented.
- o_x_nib  output  4  current x nibble.
- o_y_nib  output  4  current y nibble.
- o_last  output  1  final beat of the frame.
- o_busy  output  1  frame captured and not yet fully accepted.

Function
REQ-005 The module SHALL be the transmit-side mirror of the 4-bit operand loader: it streams captured 32-bit results out 4 bits per beat, least-significant nibble first.
REQ-006 The state machine SHALL have three states: IDLE, SEND and WAIT_LOW.
REQ-007 The module SHALL register i_done every cycle into done_q, which resets to 0.
- A rising edge is i_done=1 and done_q=0.
REQ-008 In IDLE, a rising edge in cycle T SHALL load i_x and i_y into shift registers, clear the beat counter, and enter SEND at cycle T+1.
- o_valid SHALL first be 1 in cycle T+1.
REQ-009 In SEND, o_valid SHALL be 1, o_x_nib SHALL be shift_x[3:0], and o_y_nib SHALL be shift_y[3:0].
REQ-010 A beat SHALL be accepted in any cycle where o_valid=1 and i_ready=1.
- On acceptance, both shift registers SHALL shift right by 4 and the beat counter SHALL increment.
- With i_ready=0, all outputs and state SHALL hold unchanged (backpressure, no beat loss).
REQ-011 o_last SHALL be 1 only while o_valid=1 and the beat counter equals the final beat index.
REQ-012 Acceptance of the final beat SHALL move the state machine to WAIT_LOW.
- In WAIT_LOW, o_valid=0 and o_busy=0.
- The state machine SHALL return to IDLE in the first cycle i_done=0.
- A held-high i_done SHALL never retrigger a frame.
REQ-013 o_busy SHALL be 1 exactly while in SEND.
REQ-014 A rising edge of i_done during SEND SHALL be ignored; the captured data SHALL NOT change mid-frame.
REQ-015 Outside SEND, o_valid, o_last, o_x_nib and o_y_nib SHALL be 0.
REQ-016 The beat counter SHALL be wide enough for BEATS+1 values and SHALL NOT wrap within a frame.

Reset
REQ-017 While i_rst=1 at a clock edge, the module SHALL enter IDLE and clear the shift registers, beat counter and done_q, all of which SHALL be 0.
- All outputs SHALL be 0 in the following cycle.
REQ-018 A reset asserted mid-frame SHALL abort the frame with no further beats emitted.
- If i_done is still 1 after reset releases, the reset value done_q=0 SHALL cause a new capture.

Configuration
REQ-019 With macro UNLOAD_CHECK_EN defined, each frame SHALL append one extra beat after the BEATS data beats.
- o_x_nib SHALL carry the XOR of all x data nibbles and o_y_nib the XOR of all y data nibbles.
- o_last SHALL move to this check beat, which obeys the same i_ready rules.
REQ-020 Without UNLOAD_CHECK_EN, a frame SHALL be exactly BEATS beats and no check logic SHALL be synthesized.

Verification
REQ-021 Basic frame: i_x=0x12345678, i_y=0x9ABCDEF0, i_ready=1, i_done pulsed at T.
- x beats 8,7,6,5,4,3,2,1 and y beats 0,F,E,D,C,B,A,9 in cycles T+1..T+8.
- o_last=1 only at T+8.
REQ-022 Backpressure: same data, i_ready=0 during beats 3 and 6 for two cycles each.
- The held nibbles are repeated, none are lost, and the frame ends at T+12.
REQ-023 Held done: i_done stays 1 for 20 cycles.
- Exactly one frame is emitted, and a new frame starts only after i_done drops and rises again.
REQ-024 Reset mid-frame: i_rst=1 at beat 4 with i_done still high.
- Next cycle all outputs are 0, then a new full frame starts from nibble 8.
REQ-025 Retrigger during SEND: an i_done edge at beat 2 with new i_x=0xFFFFFFFF.
- The original nibbles continue unchanged.
REQ-026 UNLOAD_CHECK_EN defined, REQ-021 data:
- A ninth beat carries x=0x8 and y=0x8, with o_last=1 at T+9 and 0 at T+8.
